csr_perf_counters: RTL and testbench

//  Machine/user performance-counter CSR unit: mcycle, minstret, NUM_HPM mhpmcounters, mcountinhibit.

---
 rtl/csr_perf_counters_pkg.sv | 40 ++++
 rtl/csr_perf_counters_if.sv | 19 +
 rtl/csr_perf_counters_counter.sv | 47 ++++
 rtl/csr_perf_counters.sv | 109 ++++++++++
 tb/tb_csr_perf_counters.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_perf_counters_pkg.sv
// Shared types and constants for the performance-counter CSR unit.
//   csr_op_e      : CSR access kind (read only, write, bit-set, bit-clear)
//   CSR_* addrs   : base addresses of the machine and user counter windows
//   CNT_* indices : counter slot numbers; mcountinhibit uses the same bit positions
//   csr_merge()   : combines the old CSR value with the operand for a given op
package csr_perf_counters_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_op_e;

  // Window bases: bits [4:0] select the counter slot, bit 7 selects the high half.
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam int          CSR_HI_BIT        = 7;

  // Counter slot indices; slot 1 (time) belongs to the timer block, so it is unmapped here.
  localparam int CNT_CY  = 0;
  localparam int CNT_TM  = 1;
  localparam int CNT_IR  = 2;
  localparam int CNT_HPM = 3;

  function automatic logic [31:0] csr_merge(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old_val | wdata;
      CSR_OP_CLEAR: res = old_val & ~wdata;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_perf_counters_if.sv
// CSR access bus between the EX-stage CSR path (master) and the counter unit (slave).
//   csr_req/csr_addr/csr_op/csr_wdata : request, driven by master
//   rd_valid/rd_data/illegal          : registered response, driven by slave
interface csr_perf_counters_if;
  import csr_perf_counters_pkg::*;

  logic        csr_req;
  logic [11:0] csr_addr;
  csr_op_e     csr_op;
  logic [31:0] csr_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        illegal;

  modport master (output csr_req, csr_addr, csr_op, csr_wdata,
                  input  rd_valid, rd_data, illegal);
  modport slave  (input  csr_req, csr_addr, csr_op, csr_wdata,
                  output rd_valid, rd_data, illegal);
endinterface

// File: rtl/csr_perf_counters_counter.sv
// One CNT_WIDTH-bit performance counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : amount added this cycle when not inhibited
//   inhibit  : freeze the counter
//   wr_lo    : replace bits [31:0] with wdata
//   wr_hi    : replace bits [CNT_WIDTH-1:32] with the low bits of wdata
//   value    : current count
// A write to either half suppresses that cycle's increment.
module csr_perf_counters_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] inc,
  input  logic                 inhibit,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo) begin
      cnt_d[31:0] = wdata;
    end else if (wr_hi) begin
      cnt_d[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
    end else if (!inhibit) begin
      cnt_d = cnt_q + inc;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/csr_perf_counters.sv
// Performance-counter CSR unit: mcycle, minstret, NUM_HPM mhpmcounters, mcountinhibit.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : CSR request / registered response (slave side)
//   retire_cnt : instructions retired this cycle (minstret increment)
//   hpm_event  : one-cycle event pulses, bit i advances mhpmcounter(3+i)
// Reads return the value before this cycle's write/increment, one cycle later.
// User aliases (Cxx) are read-only; any modifying op to them faults.
module csr_perf_counters
  import csr_perf_counters_pkg::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter int NUM_HPM   = 4,
  parameter int RETIRE_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  csr_perf_counters_if.slave  bus,
  input  logic [RETIRE_W-1:0] retire_cnt,
  input  logic [NUM_HPM-1:0]  hpm_event
);

  // Writable mcountinhibit bits: CY, IR and one per implemented HPM counter.
  localparam logic [31:0] INH_MASK =
    32'((64'd1 << CNT_CY) | (64'd1 << CNT_IR) | (((64'd1 << NUM_HPM) - 64'd1) << CNT_HPM));

  logic [4:0]           idx;
  logic                 hi, m_blk, u_blk, is_inh, legal, wr_en;
  logic [31:0]          old_val, new_val;
  logic [CNT_WIDTH-1:0] cnt_val [32];

  logic [31:0] inhibit_q, inhibit_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        illegal_q, illegal_d;

  // Address decode and op merge.
  always_comb begin
    idx     = bus.csr_addr[4:0];
    hi      = bus.csr_addr[CSR_HI_BIT];
    m_blk   = (bus.csr_addr[11:8] == CSR_MCYCLE[11:8]) && (bus.csr_addr[6:5] == 2'b00);
    u_blk   = (bus.csr_addr[11:8] == CSR_CYCLE[11:8])  && (bus.csr_addr[6:5] == 2'b00);
    is_inh  = (bus.csr_addr == CSR_MCOUNTINHIBIT);
    legal   = is_inh
           || (m_blk && (idx != 5'(CNT_TM)))
           || (u_blk && (idx != 5'(CNT_TM)) && (bus.csr_op == CSR_OP_NONE));
    old_val = is_inh ? inhibit_q
            : hi     ? 32'(cnt_val[idx] >> 32)
                     : cnt_val[idx][31:0];
    new_val = csr_merge(bus.csr_op, old_val, bus.csr_wdata);
    // SET/CLEAR with a zero operand is a pure read and must not stall counting.
    wr_en   = bus.csr_req && legal && !u_blk
           && ((bus.csr_op == CSR_OP_WRITE)
               || ((bus.csr_op != CSR_OP_NONE) && (bus.csr_wdata != 32'd0)));
  end

  // Inhibit register and registered read response.
  always_comb begin
    inhibit_d  = (wr_en && is_inh) ? (new_val & INH_MASK) : inhibit_q;
    rd_valid_d = bus.csr_req;
    illegal_d  = bus.csr_req && !legal;
    rd_data_d  = bus.csr_req ? (legal ? old_val : 32'd0) : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      inhibit_q  <= inhibit_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.illegal  = illegal_q;

  // Counter slots; unimplemented slots read as zero.
  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if (i == CNT_CY || i == CNT_IR || (i >= CNT_HPM && i < CNT_HPM + NUM_HPM)) begin : g_impl
      logic [CNT_WIDTH-1:0] inc;
      if (i == CNT_CY) begin : g_cy
        assign inc = CNT_WIDTH'(1);
      end else if (i == CNT_IR) begin : g_ir
        assign inc = CNT_WIDTH'(retire_cnt);
      end else begin : g_hpm
        assign inc = CNT_WIDTH'(hpm_event[i-CNT_HPM]);
      end

      csr_perf_counters_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .inhibit (inhibit_q[i]),
        .wr_lo   (wr_en && m_blk && !hi && (idx == 5'(i))),
        .wr_hi   (wr_en && m_blk &&  hi && (idx == 5'(i))),
        .wdata   (new_val),
        .value   (cnt_val[i])
      );
    end else begin : g_none
      assign cnt_val[i] = '0;
    end
  end

endmodule

// File: tb/tb_csr_perf_counters.sv
// Self-checking bench for csr_perf_counters: a behavioural model of the CSR
// map checked every cycle, plus hand-computed directed expectations.
module tb_csr_perf_counters;
  import csr_perf_counters_pkg::*;

  localparam int CNT_WIDTH = 64;
  localparam int NUM_HPM   = 4;
  localparam int RETIRE_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [NUM_HPM-1:0]  hpm_event;

  csr_perf_counters_if bus ();

  csr_perf_counters #(
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_HPM   (NUM_HPM),
    .RETIRE_W  (RETIRE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .retire_cnt (retire_cnt),
    .hpm_event  (hpm_event)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_cnt [32];
  logic [31:0]     m_inh;
  logic            m_valid, m_ill;
  logic [31:0]     m_data;

  function automatic bit m_impl(int n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [11:0]     a, base;
    int              n;
    bit              hi, is_inh, ro, ok, wr;
    logic [31:0]     old, nw, mask;
    longint unsigned inc;
    if (rst) begin
      for (int k = 0; k < 32; k++) m_cnt[k] = 0;
      m_inh = 0; m_valid = 0; m_ill = 0; m_data = 0;
    end else begin
      a      = bus.csr_addr;
      n      = int'(a[4:0]);
      hi     = a[7];
      base   = a & ~12'h09F;
      is_inh = (a == 12'h320);
      ro     = (base == 12'hC00);
      ok     = is_inh || (((base == 12'hB00) || ro) && n != 1);
      if (ro && bus.csr_op != CSR_OP_NONE) ok = 0;
      old = is_inh ? m_inh : hi ? m_cnt[n][63:32] : m_cnt[n][31:0];
      case (bus.csr_op)
        CSR_OP_WRITE: nw = bus.csr_wdata;
        CSR_OP_SET:   nw = old | bus.csr_wdata;
        default:      nw = old & ~bus.csr_wdata;
      endcase
      wr = bus.csr_req && ok && !ro && bus.csr_op != CSR_OP_NONE &&
           (bus.csr_op == CSR_OP_WRITE || bus.csr_wdata != 0);
      if (bus.csr_req) begin
        m_valid = 1; m_ill = !ok; m_data = ok ? old : 32'd0;
      end else begin
        m_valid = 0; m_ill = 0;
      end
      for (int k = 0; k < 32; k++) begin
        if (m_impl(k)) begin
          inc = (k == 0) ? 1 : (k == 2) ? longint'(retire_cnt) : longint'(hpm_event[k-3]);
          if (wr && !is_inh && n == k) begin
            if (hi) m_cnt[k] = {nw, m_cnt[k][31:0]};
            else    m_cnt[k] = {m_cnt[k][63:32], nw};
          end else if (!m_inh[k]) begin
            m_cnt[k] = m_cnt[k] + inc;
          end
        end
      end
      mask = 0;
      for (int b = 0; b < 32; b++) mask[b] = m_impl(b);
      if (wr && is_inh) m_inh = nw & mask;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
      check("illegal",  32'(bus.illegal),  32'(m_ill));
      check("rd_data",  bus.rd_data,       m_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input csr_op_e op, input logic [31:0] wd,
                     output logic [31:0] d, output logic il);
    bus.csr_req   = 1'b1;
    bus.csr_addr  = a;
    bus.csr_op    = op;
    bus.csr_wdata = wd;
    @(posedge clk);
    #1;
    d = bus.rd_data;
    il = bus.illegal;
    bus.csr_req = 1'b0;
    bus.csr_op  = CSR_OP_NONE;
  endtask

  logic [31:0] d;
  logic        il;

  initial begin
    rst = 1'b1;
    bus.csr_req = 1'b0; bus.csr_addr = '0; bus.csr_op = CSR_OP_NONE; bus.csr_wdata = '0;
    retire_cnt = '0; hpm_event = '0;
    idle(3);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_data",  bus.rd_data,       32'd0);
    check("reset_illegal",  32'(bus.illegal),  32'd0);
    rst = 1'b0;

    // Idle count after reset release.
    idle(10);
    csr(12'hC00, CSR_OP_NONE, 0, d, il);
    check("cycle_after_10", d, 32'd10);
    check("cycle_legal", 32'(il), 32'd0);

    // Carry from low half into high half.
    csr(12'hB00, CSR_OP_WRITE, 32'hFFFF_FFFF, d, il);
    csr(12'hB80, CSR_OP_NONE, 0, d, il);
    check("mcycleh_before_carry", d, 32'd0);
    idle(1);
    csr(12'hB80, CSR_OP_NONE, 0, d, il);
    check("mcycleh_after_carry", d, 32'd1);

    // Illegal accesses.
    csr(12'hC00, CSR_OP_WRITE, 32'hDEAD, d, il);
    check("write_user_alias_illegal", 32'(il), 32'd1);
    check("write_user_alias_data", d, 32'd0);
    csr(12'h7FF, CSR_OP_NONE, 0, d, il);
    check("unmapped_illegal", 32'(il), 32'd1);
    check("unmapped_data", d, 32'd0);
    csr(12'hB01, CSR_OP_NONE, 0, d, il);
    check("time_slot_illegal", 32'(il), 32'd1);
    csr(12'hB80, CSR_OP_NONE, 0, d, il);
    check("mcycleh_untouched", d, 32'd1);

    // Inhibit register writable bits.
    csr(12'h320, CSR_OP_WRITE, 32'hFFFF_FFFF, d, il);
    csr(12'h320, CSR_OP_NONE, 0, d, il);
    check("inhibit_mask", d, 32'h0000_007D);
    csr(12'h320, CSR_OP_WRITE, 32'h0, d, il);

    // minstret inhibit and resume.
    csr(12'h320, CSR_OP_SET, 32'h4, d, il);
    retire_cnt = 2'd3;
    idle(5);
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_inhibited", d, 32'd0);
    retire_cnt = 2'd0;
    csr(12'h320, CSR_OP_CLEAR, 32'h4, d, il);
    retire_cnt = 2'd3;
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_resume0", d, 32'd0);
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_resume1", d, 32'd3);
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_resume2", d, 32'd6);

    // Write beats increment.
    retire_cnt = 2'd2;
    csr(12'hB02, CSR_OP_WRITE, 32'd100, d, il);
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_written", d, 32'd100);
    csr(12'hB02, CSR_OP_NONE, 0, d, il);
    check("minstret_next", d, 32'd102);
    retire_cnt = 2'd0;

    // Zero-operand SET/CLEAR are reads only.
    csr(12'hB00, CSR_OP_SET, 32'h0, d, il);
    csr(12'hB00, CSR_OP_CLEAR, 32'h0, d, il);

    // HPM event counting and unimplemented slots.
    for (int p = 0; p < 3; p++) begin
      hpm_event = 4'b0010;
      idle(1);
      hpm_event = 4'b0000;
      idle(1);
    end
    csr(12'hB04, CSR_OP_NONE, 0, d, il);
    check("hpm4_events", d, 32'd3);
    csr(12'hB0A, CSR_OP_WRITE, 32'd7, d, il);
    csr(12'hB0A, CSR_OP_NONE, 0, d, il);
    check("hpm10_reads_zero", d, 32'd0);
    check("hpm10_legal", 32'(il), 32'd0);
    csr(12'hB83, CSR_OP_WRITE, 32'd5, d, il);
    csr(12'hC83, CSR_OP_NONE, 0, d, il);
    check("hpm3h_written", d, 32'd5);

    // Reset in the middle of a response.
    bus.csr_req = 1'b1; bus.csr_addr = 12'hC00; bus.csr_op = CSR_OP_NONE;
    @(posedge clk);
    #1;
    bus.csr_req = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("midreset_rd_data",  bus.rd_data,       32'd0);
    idle(2);
    rst = 1'b0;
    idle(3);
    csr(12'hC00, CSR_OP_NONE, 0, d, il);
    check("cycle_after_midreset", d, 32'd3);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
